// File: rtl/uart_aes_block_loader_pkg.sv
// uart_aes_block_loader_pkg: RX state encodings, AES block width and a clog2 helper.
package uart_aes_block_loader_pkg;
  typedef enum logic [2:0] {ST_Idle, ST_Start, ST_Data, ST_Parity, ST_Stop} rx_state_t;
  localparam int AESBlockWidth = 128;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/uart_aes_block_loader_rx.sv
// uart_rx_byte: synchronized UART receiver, 8N1 or 8E1 when UART_RX_PARITY_EN is defined.
module uart_rx_byte
  import uart_aes_block_loader_pkg::*;
#(
  parameter int ClocksPerBit = 1736
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       RX,
  output logic [7:0] Byte,
  output logic       ByteValid,
  output logic       FramingError,
  output logic       ParityError
);
  localparam int TW = clog2(ClocksPerBit);
  localparam logic [TW-1:0] L_FULL = TW'(ClocksPerBit - 1);
  localparam logic [TW-1:0] L_HALF = TW'(ClocksPerBit / 2 - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t ST_AfterData = ST_Parity;
`else
  localparam rx_state_t ST_AfterData = ST_Stop;
`endif
  logic [1:0]    r_sync;
  rx_state_t     r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_idx;
  logic [7:0]    r_data;
  logic          w_rx_s;
  logic          w_tick;
  logic          w_par_ok;
  assign w_rx_s = r_sync[1];
  assign w_tick = r_timer == '0;
`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_error;
  assign w_par_ok    = !r_par_bad;
  assign ParityError = r_parity_error;
`else
  assign w_par_ok    = 1'b1;
  assign ParityError = 1'b0;
`endif
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], RX};
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      r_state      <= ST_Idle;
      r_timer      <= L_HALF;
      r_idx        <= '0;
      r_data       <= '0;
      Byte         <= '0;
      ByteValid    <= 1'b0;
      FramingError <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad      <= 1'b0;
      r_parity_error <= 1'b0;
`endif
    end else begin
      ByteValid    <= 1'b0;
      FramingError <= 1'b0;
      r_timer      <= w_tick ? L_FULL : r_timer - 1'b1;
`ifdef UART_RX_PARITY_EN
      r_parity_error <= 1'b0;
`endif
      case (r_state)
        ST_Idle: begin
          r_timer <= L_HALF;
`ifdef UART_RX_PARITY_EN
          r_par_bad <= 1'b0;
`endif
          if (!w_rx_s) r_state <= ST_Start;
        end
        ST_Start: if (w_tick) r_state <= w_rx_s ? ST_Idle : ST_Data;
        ST_Data: if (w_tick) begin
          r_data <= {w_rx_s, r_data[7:1]};
          r_idx  <= r_idx + 1'b1;
          if (r_idx == 3'd7) r_state <= ST_AfterData;
        end
`ifdef UART_RX_PARITY_EN
        ST_Parity: if (w_tick) begin
          r_par_bad      <= w_rx_s != ^r_data;
          r_parity_error <= w_rx_s != ^r_data;
          r_state        <= ST_Stop;
        end
`endif
        ST_Stop: if (w_tick) begin
          // Back to idle on the sample cycle so a start bit right after is caught.
          r_state      <= ST_Idle;
          ByteValid    <= w_rx_s && w_par_ok;
          FramingError <= !w_rx_s;
          if (w_rx_s && w_par_ok) Byte <= r_data;
        end
        default: r_state <= ST_Idle;
      endcase
    end
endmodule

// File: rtl/uart_aes_block_loader.sv
// uart_aes_block_loader: packs UART bytes into 128-bit AES blocks behind a valid/ready holding register.
// Optional even parity via UART_RX_PARITY_EN.
module uart_aes_block_loader
  import uart_aes_block_loader_pkg::*;
#(
  parameter int ClocksPerBit = 1736,
  parameter int BlockBytes   = 16
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     UARTRX,
  output logic [AESBlockWidth-1:0] DataOut,
  output logic                     DataOutValid,
  input  logic                     DataOutReady,
  output logic                     FramingError,
  output logic                     ParityError,
  output logic                     Overflow
);
  localparam int CW = clog2(BlockBytes);
  localparam logic [CW-1:0] L_LAST = CW'(BlockBytes - 1);
  logic [7:0]               w_byte;
  logic                     w_byte_valid;
  logic [AESBlockWidth-1:0] w_block;
  logic [AESBlockWidth-9:0] r_shift;
  logic [CW-1:0]            r_count;
  assign w_block = {r_shift, w_byte};
  uart_rx_byte #(.ClocksPerBit(ClocksPerBit)) u_rx (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .RX           (UARTRX),
    .Byte         (w_byte),
    .ByteValid    (w_byte_valid),
    .FramingError (FramingError),
    .ParityError  (ParityError)
  );
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      r_shift      <= '0;
      r_count      <= '0;
      DataOut      <= '0;
      DataOutValid <= 1'b0;
      Overflow     <= 1'b0;
    end else begin
      Overflow <= 1'b0;
      if (DataOutValid && DataOutReady) DataOutValid <= 1'b0;
      if (w_byte_valid) begin
        r_shift <= w_block[AESBlockWidth-9:0];
        r_count <= r_count == L_LAST ? '0 : r_count + 1'b1;
        // A block completing while the held one is unaccepted is dropped.
        if (r_count == L_LAST) begin
          if (!DataOutValid || DataOutReady) begin
            DataOut      <= w_block;
            DataOutValid <= 1'b1;
          end else Overflow <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_uart_aes_block_loader.sv
// tb_uart_aes_block_loader: directed checks of byte packing, backpressure, errors and reset.
module tb_uart_aes_block_loader;
  localparam int CPB = 16;
  logic         clk = 1'b0;
  logic         Reset_n;
  logic         UARTRX;
  logic         DataOutReady;
  logic [127:0] DataOut;
  logic         DataOutValid;
  logic         FramingError;
  logic         ParityError;
  logic         Overflow;
  int n_tests = 0, n_fail = 0;
  int n_fe = 0, n_pe = 0, n_ov = 0, n_vcyc = 0;
  logic [127:0] q[$];

  uart_aes_block_loader #(.ClocksPerBit(CPB), .BlockBytes(16)) dut (
    .Clock        (clk),
    .Reset_n      (Reset_n),
    .UARTRX       (UARTRX),
    .DataOut      (DataOut),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady),
    .FramingError (FramingError),
    .ParityError  (ParityError),
    .Overflow     (Overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (Reset_n) begin
      if (FramingError) n_fe++;
      if (ParityError) n_pe++;
      if (Overflow) n_ov++;
      if (DataOutValid) n_vcyc++;
      if (DataOutValid && DataOutReady) q.push_back(DataOut);
    end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pop_blk();
    logic [127:0] b;
    b = '0;
    if (q.size() > 0) b = q.pop_front();
    return b;
  endfunction

  task automatic put_bit(input logic v);
    UARTRX = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1, input logic par_bad = 1'b0);
    @(posedge clk);
    #1;
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    put_bit((^b) ^ par_bad);
`endif
    put_bit(stop_ok);
    put_bit(1'b1);
  endtask

  task automatic send_run(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send_byte(8'(base + 8'(i)));
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1;
    DataOutReady = v;
  endtask

  initial begin
    int v0, f0, o0, p0;
    Reset_n = 1'b0;
    UARTRX = 1'b1;
    DataOutReady = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    Reset_n = 1'b1;
    repeat (20 * CPB) @(posedge clk);
    #1;
    check_eq("reset_dataout", DataOut, '0);
    check_eq("reset_valid", 128'(DataOutValid), 128'(0));
    check_eq("reset_pulses", 128'(n_fe + n_pe + n_ov + n_vcyc), 128'(0));

    set_ready(1'b1);
    v0 = n_vcyc;
    send_run(8'h00, 16);
    repeat (4) @(posedge clk);
    check_eq("basic_nblk", 128'(q.size()), 128'(1));
    check_eq("basic_block", pop_blk(), 128'h000102030405060708090A0B0C0D0E0F);
    check_eq("basic_vcycles", 128'(n_vcyc - v0), 128'(1));

    set_ready(1'b0);
    send_run(8'h10, 16);
    check_eq("bp_valid", 128'(DataOutValid), 128'(1));
    check_eq("bp_data", DataOut, 128'h101112131415161718191A1B1C1D1E1F);
    send_run(8'h20, 10);
    check_eq("bp_hold", DataOut, 128'h101112131415161718191A1B1C1D1E1F);
    check_eq("bp_nblk", 128'(q.size()), 128'(0));
    set_ready(1'b1);
    @(posedge clk);
    #1;
    check_eq("bp_valid_drop", 128'(DataOutValid), 128'(0));
    check_eq("bp_first", pop_blk(), 128'h101112131415161718191A1B1C1D1E1F);
    send_run(8'h2A, 6);
    repeat (4) @(posedge clk);
    check_eq("bp_second", pop_blk(), 128'h202122232425262728292A2B2C2D2E2F);

    f0 = n_fe;
    for (int i = 0; i < 17; i++) send_byte(8'(i), i != 3);
    repeat (4) @(posedge clk);
    check_eq("fe_count", 128'(n_fe - f0), 128'(1));
    check_eq("fe_block", pop_blk(), 128'h0001020405060708090A0B0C0D0E0F10);

    f0 = n_fe;
    @(posedge clk);
    #1;
    UARTRX = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1;
    UARTRX = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check_eq("glitch_nblk", 128'(q.size()), 128'(0));
    check_eq("glitch_fe", 128'(n_fe - f0), 128'(0));
    send_run(8'hF0, 16);
    repeat (4) @(posedge clk);
    check_eq("glitch_block", pop_blk(), 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);

    set_ready(1'b0);
    o0 = n_ov;
    send_run(8'h40, 32);
    check_eq("ov_count", 128'(n_ov - o0), 128'(1));
    check_eq("ov_held", DataOut, 128'h404142434445464748494A4B4C4D4E4F);
    set_ready(1'b1);
    repeat (4) @(posedge clk);
    check_eq("ov_block", pop_blk(), 128'h404142434445464748494A4B4C4D4E4F);
    check_eq("ov_nblk", 128'(q.size()), 128'(0));
    check_eq("ov_valid", 128'(DataOutValid), 128'(0));

`ifdef UART_RX_PARITY_EN
    p0 = n_pe;
    send_byte(8'hA5, 1'b1, 1'b1);
    send_run(8'h70, 16);
    repeat (4) @(posedge clk);
    check_eq("par_count", 128'(n_pe - p0), 128'(1));
    check_eq("par_block", pop_blk(), 128'h707172737475767778797A7B7C7D7E7F);
`else
    p0 = n_pe;
    send_byte(8'hA5);
    check_eq("par_tied", 128'(n_pe - p0), 128'(0));
`endif

    set_ready(1'b0);
    send_run(8'h30, 21);
    @(posedge clk);
    #1;
    Reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mid_valid", 128'(DataOutValid), 128'(0));
    check_eq("rst_mid_data", DataOut, '0);
    Reset_n = 1'b1;
    set_ready(1'b1);
    send_run(8'h60, 16);
    repeat (4) @(posedge clk);
    check_eq("rst_mid_nblk", 128'(q.size()), 128'(1));
    check_eq("rst_mid_block", pop_blk(), 128'h606162636465666768696A6B6C6D6E6F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
